// File: rtl/updown_counter_param_if.sv
// rtl/updown_counter_param_if.sv - control and status bundle for the parametrised up/down counter
interface updown_counter_param_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              en;
  logic              up;
  logic [STEP_W-1:0] step;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              clr_flags;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              ovf_sticky;
  logic              unf_sticky;
  logic              at_max;
  logic              at_min;

  modport master (
    output en, up, step, load, load_val, clr_flags,
    input  count, tc, ovf_sticky, unf_sticky, at_max, at_min
  );

  modport slave (
    input  en, up, step, load, load_val, clr_flags,
    output count, tc, ovf_sticky, unf_sticky, at_max, at_min
  );
endinterface

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - up/down counter with programmable modulus, step, load and wrap/saturate
module updown_counter_param #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter bit SATURATE = 1'b0,
  parameter int STEP_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_counter_param_if.slave bus
);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             ovf_q;
  logic             unf_q;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   s_eff;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH-1:0] count_d;
  logic             ovf_evt;
  logic             unf_evt;

  // One extra bit of headroom keeps count+s and count+MOD-s exact before folding back.
  always_comb begin
    step_ext = (WIDTH+1)'(bus.step);
    s_eff    = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
    cnt_ext  = {1'b0, count_q};
    sum_ext  = cnt_ext + s_eff;
    load_ext = {1'b0, bus.load_val};
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    count_d  = count_q;
    if (bus.load) begin
      count_d = (load_ext > MAX_EXT) ? MAX_CNT : bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (sum_ext > MAX_EXT) begin
          ovf_evt = 1'b1;
          count_d = SATURATE ? MAX_CNT : WIDTH'(sum_ext - MOD_EXT);
        end else begin
          count_d = WIDTH'(sum_ext);
        end
      end else begin
        if (s_eff > cnt_ext) begin
          unf_evt = 1'b1;
          count_d = SATURATE ? '0 : WIDTH'(cnt_ext + MOD_EXT - s_eff);
        end else begin
          count_d = WIDTH'(cnt_ext - s_eff);
        end
      end
    end
  end

  // A boundary event in the same cycle as clr_flags leaves its flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= ovf_evt | unf_evt;
      ovf_q   <= ovf_evt | (ovf_q & ~bus.clr_flags);
      unf_q   <= unf_evt | (unf_q & ~bus.clr_flags);
    end
  end

  assign bus.count      = count_q;
  assign bus.tc         = tc_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.unf_sticky = unf_q;
  assign bus.at_max     = (count_q == MAX_CNT);
  assign bus.at_min     = (count_q == '0);
endmodule
